// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: RF widths, the buffered MDU
// entry {squash, addr, data} and the write-source selector.
package rf_wb_arbiter_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;

  // 38-bit entry word: squash at the top, then addr, then data.
  typedef struct packed {
    logic     squash;
    rf_addr_t addr;
    rf_data_t data;
  } rf_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WB,
    SRC_FIFO,
    SRC_MDU
  } wr_src_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// DEPTH-entry FIFO of MDU results with a parallel squash-by-address port.
// Per-entry live/addr taps exist only when RFWB_BUSY_MASK_EN is defined.
module rf_wb_fifo
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  rf_entry_t  push_entry,
  input  logic       pop,
  output rf_entry_t  head,
  output logic       full,
  output logic       empty,
`ifdef RFWB_BUSY_MASK_EN
  output logic [DEPTH-1:0] ent_live,
  output rf_addr_t   ent_addr [DEPTH],
`endif
  input  logic       sq_en,
  input  rf_addr_t   sq_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  rf_entry_t         mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [PW-1:0]     offset [DEPTH];
  logic [DEPTH-1:0]  valid;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      offset[i] = PW'(i) - rd_ptr;
      valid[i]  = ({1'b0, offset[i]} < count);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count alone decide which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (sq_en && valid[i] && (mem[i].addr == sq_addr)) mem[i].squash <= 1'b1;
    end
    if (push) mem[wr_ptr] <= push_entry;
  end

`ifdef RFWB_BUSY_MASK_EN
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_live[i] = valid[i] && !mem[i].squash;
      ent_addr[i] = mem[i].addr;
    end
  end
`endif

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the RF write port between the WB stage (fixed priority) and buffered MDU results,
// with WAW squash and a starvation stall. Optional busy_mask output: RFWB_BUSY_MASK_EN.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pl_wr,
  input  logic [RF_AW-1:0] pl_addr,
  input  logic [RF_DW-1:0] pl_data,
  output logic             pl_stall,
  input  logic             mdu_valid,
  output logic             mdu_ready,
  input  logic [RF_AW-1:0] mdu_addr,
  input  logic [RF_DW-1:0] mdu_data,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_a3,
  output logic [RF_DW-1:0] rf_wd
`ifdef RFWB_BUSY_MASK_EN
  ,
  output logic [31:0]      busy_mask
`endif
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic      fifo_full;
  logic      fifo_empty;
  logic      fifo_push;
  logic      fifo_pop;
  rf_entry_t fifo_head;
  rf_entry_t push_entry;
  logic      pl_grant;
  logic      mdu_acc;
  logic      mdu_live;
  wr_src_e   wr_src;
  logic [SW-1:0] starve_cnt;

`ifdef RFWB_BUSY_MASK_EN
  logic [DEPTH-1:0] ent_live;
  rf_addr_t         ent_addr [DEPTH];
`endif

  assign mdu_ready  = !fifo_full;
  assign push_entry = '{squash: 1'b0, addr: mdu_addr, data: mdu_data};

  // NOTE: every signal gets its default before the if-chain so no latch is inferred.
  always_comb begin
    pl_grant = pl_wr && (pl_addr != '0);
    mdu_acc  = mdu_valid && mdu_ready;
    mdu_live = mdu_acc && (mdu_addr != '0);
    wr_src   = SRC_NONE;
    if (pl_grant)        wr_src = SRC_WB;
    else if (!fifo_empty) wr_src = SRC_FIFO;
    else if (mdu_live)   wr_src = SRC_MDU;
    fifo_pop  = (wr_src == SRC_FIFO);
    // A same-cycle WB write to the same register makes the MDU result dead on arrival.
    fifo_push = mdu_live && (wr_src != SRC_MDU) && !(pl_grant && (mdu_addr == pl_addr));
  end

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
`ifdef RFWB_BUSY_MASK_EN
    .ent_live   (ent_live),
    .ent_addr   (ent_addr),
`endif
    .sq_en      (pl_grant),
    .sq_addr    (pl_addr)
  );

  // NOTE: sequential state uses <= only; the early defaults are overridden by later <=.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rf_we      <= 1'b0;
      rf_a3      <= '0;
      rf_wd      <= '0;
      pl_stall   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      rf_we    <= 1'b0;
      pl_stall <= 1'b0;
      unique case (wr_src)
        SRC_WB: begin
          rf_we <= 1'b1;
          rf_a3 <= pl_addr;
          rf_wd <= pl_data;
        end
        SRC_FIFO: begin
          if (!fifo_head.squash) begin
            rf_we <= 1'b1;
            rf_a3 <= fifo_head.addr;
            rf_wd <= fifo_head.data;
          end
        end
        SRC_MDU: begin
          rf_we <= 1'b1;
          rf_a3 <= mdu_addr;
          rf_wd <= mdu_data;
        end
        default: ;
      endcase
      // The loss that brings the count to STARVE_MAX raises the stall for the next cycle.
      if (pl_grant && !fifo_empty) begin
        if (starve_cnt == SW'(STARVE_MAX - 1)) begin
          pl_stall   <= 1'b1;
          starve_cnt <= '0;
        end else begin
          starve_cnt <= starve_cnt + SW'(1);
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

`ifdef RFWB_BUSY_MASK_EN
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_live[i]) busy_mask[ent_addr[i]] = 1'b1;
    end
    busy_mask[0] = 1'b0;
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vector table, reset-mid-operation sequence and a
// randomized run against a queue-based reference model.
module tb_rf_wb_arbiter;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;
  localparam int NTBL       = 22;
  localparam int NRAND      = 3000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pl_wr = 1'b0;
  logic [4:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  logic        pl_stall;
  logic        mdu_valid = 1'b0;
  logic        mdu_ready;
  logic [4:0]  mdu_addr = '0;
  logic [31:0] mdu_data = '0;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
`ifdef RFWB_BUSY_MASK_EN
  logic [31:0] busy_mask;
`endif

  rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .pl_wr     (pl_wr),
    .pl_addr   (pl_addr),
    .pl_data   (pl_data),
    .pl_stall  (pl_stall),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_addr  (mdu_addr),
    .mdu_data  (mdu_data),
    .rf_we     (rf_we),
    .rf_a3     (rf_a3),
    .rf_wd     (rf_wd)
`ifdef RFWB_BUSY_MASK_EN
    ,
    .busy_mask (busy_mask)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    @(negedge clk);
    pl_wr     = pw;
    pl_addr   = pa;
    pl_data   = pd;
    mdu_valid = mv;
    mdu_addr  = ma;
    mdu_data  = md;
  endtask

  // Directed vectors: inputs for one cycle, mdu_ready before the edge, rf_*/pl_stall after it.
  typedef struct {
    logic        pw;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        rdy;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic        st;
  } vec_t;

  vec_t tbl [NTBL];

  function automatic vec_t mk(logic pw, logic [4:0] pa, logic [31:0] pd,
                              logic mv, logic [4:0] ma, logic [31:0] md,
                              logic rdy, logic we, logic [4:0] a3, logic [31:0] wd, logic st);
    mk = '{pw, pa, pd, mv, ma, md, rdy, we, a3, wd, st};
  endfunction

  // Reference model: the FIFO is a queue of {addr, data, squashed}.
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          sq;
  } ment_t;

  ment_t       mq [$];
  int          m_starve;
  logic        m_we;
  logic        m_stall;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_we     = 1'b0;
    m_stall  = 1'b0;
    m_a3     = '0;
    m_wd     = '0;
  endtask

  task automatic model_step(output logic exp_ready);
    bit    wb, acc, had, cut;
    ment_t e;
    had       = (mq.size() != 0);
    exp_ready = (mq.size() < DEPTH);
    acc       = mdu_valid && exp_ready;
    wb        = pl_wr && (pl_addr != 0);
    cut       = 1'b0;
    m_we      = 1'b0;
    if (wb) begin
      m_we = 1'b1; m_a3 = pl_addr; m_wd = pl_data;
      foreach (mq[i]) if (mq[i].addr == pl_addr) mq[i].sq = 1'b1;
    end else if (had) begin
      e = mq.pop_front();
      if (!e.sq) begin
        m_we = 1'b1; m_a3 = e.addr; m_wd = e.data;
      end
    end else if (acc && mdu_addr != 0) begin
      cut  = 1'b1;
      m_we = 1'b1; m_a3 = mdu_addr; m_wd = mdu_data;
    end
    if (acc && mdu_addr != 0 && !cut && !(wb && mdu_addr == pl_addr))
      mq.push_back('{mdu_addr, mdu_data, 1'b0});
    m_stall = 1'b0;
    if (wb && had) begin
      m_starve++;
      if (m_starve == STARVE_MAX) begin
        m_stall  = 1'b1;
        m_starve = 0;
      end
    end else begin
      m_starve = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_ready;

    // Directed sequence starting from an empty FIFO and zeroed outputs.
    tbl[0]  = mk(0, 0,  0,         1, 5,  32'h1234, 1, 1, 5,  32'h1234, 0); // cut-through
    tbl[1]  = mk(0, 0,  0,         0, 0,  0,        1, 0, 5,  32'h1234, 0);
    tbl[2]  = mk(1, 3,  32'hA,     1, 4,  32'hB,    1, 1, 3,  32'hA,    0); // WB priority
    tbl[3]  = mk(0, 0,  0,         0, 0,  0,        1, 1, 4,  32'hB,    0);
    tbl[4]  = mk(1, 2,  32'h22,    1, 7,  32'h1,    1, 1, 2,  32'h22,   0); // buffer r7
    tbl[5]  = mk(1, 7,  32'h2,     0, 0,  0,        1, 1, 7,  32'h2,    0); // WAW squash
    tbl[6]  = mk(0, 0,  0,         0, 0,  0,        1, 0, 7,  32'h2,    0); // squashed pop
    tbl[7]  = mk(0, 0,  0,         0, 0,  0,        1, 0, 7,  32'h2,    0);
    tbl[8]  = mk(1, 1,  32'h10,    1, 9,  32'h90,   1, 1, 1,  32'h10,   0);
    tbl[9]  = mk(1, 1,  32'h11,    1, 8,  32'h80,   1, 1, 1,  32'h11,   0); // now full
    tbl[10] = mk(1, 1,  32'h12,    1, 10, 32'hA0,   0, 1, 1,  32'h12,   0);
    tbl[11] = mk(1, 1,  32'h13,    1, 10, 32'hA0,   0, 1, 1,  32'h13,   0);
    tbl[12] = mk(1, 1,  32'h14,    1, 10, 32'hA0,   0, 1, 1,  32'h14,   1); // 4th loss
    tbl[13] = mk(0, 0,  0,         1, 10, 32'hA0,   0, 1, 9,  32'h90,   0); // stall: pop r9
    tbl[14] = mk(0, 0,  0,         1, 10, 32'hA0,   1, 1, 8,  32'h80,   0); // pop+push
    tbl[15] = mk(0, 0,  0,         0, 0,  0,        1, 1, 10, 32'hA0,   0);
    tbl[16] = mk(0, 0,  0,         0, 0,  0,        1, 0, 10, 32'hA0,   0);
    tbl[17] = mk(1, 0,  32'hDEAD,  1, 6,  32'h66,   1, 1, 6,  32'h66,   0); // pl r0 ignored
    tbl[18] = mk(0, 0,  0,         1, 0,  32'h99,   1, 0, 6,  32'h66,   0); // mdu r0 dropped
    tbl[19] = mk(1, 11, 32'hB1,    1, 11, 32'hB2,   1, 1, 11, 32'hB1,   0); // same-cycle WAW
    tbl[20] = mk(0, 0,  0,         0, 0,  0,        1, 0, 11, 32'hB1,   0);
    tbl[21] = mk(0, 0,  0,         0, 0,  0,        1, 0, 11, 32'hB1,   0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", mdu_ready, 1);
    check("rst_we",    rf_we,     0);
    check("rst_a3",    rf_a3,     0);
    check("rst_wd",    rf_wd,     0);
    check("rst_stall", pl_stall,  0);
    @(negedge clk);
    rstn = 1'b1;

    for (int r = 0; r < NTBL; r++) begin
      drive(tbl[r].pw, tbl[r].pa, tbl[r].pd, tbl[r].mv, tbl[r].ma, tbl[r].md);
      #1;
      check($sformatf("row%0d_ready", r), mdu_ready, tbl[r].rdy);
      @(posedge clk);
      #1;
      check($sformatf("row%0d_we", r),    rf_we,    tbl[r].we);
      check($sformatf("row%0d_a3", r),    rf_a3,    tbl[r].a3);
      check($sformatf("row%0d_wd", r),    rf_wd,    tbl[r].wd);
      check($sformatf("row%0d_stall", r), pl_stall, tbl[r].st);
    end

    // Reset mid-operation with two results buffered: they must never reach the RF.
    drive(1, 1, 32'h1, 1, 12, 32'hC);
    drive(1, 1, 32'h2, 1, 13, 32'hD);
    @(negedge clk);
    pl_wr = 1'b0; mdu_valid = 1'b0;
    #2;
    check("mid_full_ready", mdu_ready, 0);
    rstn = 1'b0;
    #1;
    check("mid_rst_ready", mdu_ready, 1);
    check("mid_rst_we",    rf_we,     0);
    check("mid_rst_a3",    rf_a3,     0);
    check("mid_rst_wd",    rf_wd,     0);
    check("mid_rst_stall", pl_stall,  0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst%0d_we", c),    rf_we,     0);
      check($sformatf("post_rst%0d_ready", c), mdu_ready, 1);
    end

    // Randomized run against the model; WB never writes while the model says it is stalled.
    model_reset();
    for (int c = 0; c < NRAND; c++) begin
      @(negedge clk);
      pl_wr     = !m_stall && ($urandom_range(0, 2) != 0);
      pl_addr   = 5'($urandom_range(0, 7));
      pl_data   = $urandom;
      mdu_valid = ($urandom_range(0, 1) != 0);
      mdu_addr  = 5'($urandom_range(0, 7));
      mdu_data  = $urandom;
      model_step(exp_ready);
      #1;
      check("rnd_ready", mdu_ready, exp_ready);
      @(posedge clk);
      #1;
      check("rnd_we",    rf_we,    m_we);
      check("rnd_stall", pl_stall, m_stall);
      if (m_we) begin
        check("rnd_a3", rf_a3, m_a3);
        check("rnd_wd", rf_wd, m_wd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
